// File: rtl/state_link_pkg.sv
// state_link_pkg: shared FSM states, command codes and link constants for the one-byte UDP command link
package state_link_pkg;
  typedef enum logic [1:0] {IDLE, RECV, CHECK} state_t;
  localparam logic [1:0] CMD_STOP = 2'b00;
  localparam logic [1:0] CMD_FWD = 2'b01;
  localparam logic [1:0] CMD_REV = 2'b10;
  localparam logic [1:0] CMD_HOLD = 2'b11;
  localparam logic [7:0] CMD_PAD_MASK = 8'hFC;
  localparam logic [15:0] DEFAULT_PORT = 16'd8080;
endpackage

// File: rtl/sat_counter8.sv
// sat_counter8: 8-bit counter (clk_50, sys_rst_n, inc -> cnt) that increments on inc and holds at 255
module sat_counter8 (
  input  logic       clk_50,
  input  logic       sys_rst_n,
  input  logic       inc,
  output logic [7:0] cnt
);
  always_ff @(posedge clk_50 or negedge sys_rst_n)
    if (!sys_rst_n) cnt <= '0;
    else if (inc && cnt != 8'hFF) cnt <= cnt + 8'd1;
endmodule

// File: rtl/state_receiver.sv
// state_receiver: filters app_rx UDP packets into 2-bit commands (cmd_out/cmd_valid/cmd_ack) with rx_busy and saturating ok/err/overrun counters
module state_receiver import state_link_pkg::*; #(
  parameter logic [15:0] LISTEN_PORT = DEFAULT_PORT,
  parameter logic [15:0] TIMEOUT_CYC = 16'd1000
) (
  input  logic        clk_50,
  input  logic        sys_rst_n,
  input  logic        app_rx_data_valid,
  input  logic [7:0]  app_rx_data,
  input  logic [15:0] app_rx_data_length,
  input  logic [15:0] app_rx_port_num,
  output logic [1:0]  cmd_out,
  output logic        cmd_valid,
  input  logic        cmd_ack,
  output logic        rx_busy,
  output logic [7:0]  pkt_ok_cnt,
  output logic [7:0]  pkt_err_cnt,
  output logic [7:0]  overrun_cnt
);
  state_t state;
  logic [15:0] len, port, byte_cnt, tmo_cnt;
  logic [7:0] byte0;
  logic good, hold, tmo_hit, ok_inc, ovr_inc, err_inc;
  assign good = port == LISTEN_PORT && len == 16'd1 && (byte0 & CMD_PAD_MASK) == 8'h00;
  assign hold = cmd_valid && !cmd_ack;
  assign tmo_hit = state == RECV && !app_rx_data_valid && tmo_cnt == TIMEOUT_CYC - 16'd1;
  assign ok_inc = state == CHECK && good && !hold;
  assign ovr_inc = state == CHECK && good && hold;
  assign err_inc = (state == CHECK && !good) || tmo_hit;
  always_ff @(posedge clk_50 or negedge sys_rst_n)
    if (!sys_rst_n) begin
      state <= IDLE;
      cmd_out <= '0;
      cmd_valid <= 1'b0;
      rx_busy <= 1'b0;
      len <= '0;
      port <= '0;
      byte0 <= '0;
      byte_cnt <= '0;
      tmo_cnt <= '0;
    end else begin
      if (cmd_ack) cmd_valid <= 1'b0;
      if (ok_inc) begin
        cmd_out <= byte0[1:0];
        cmd_valid <= 1'b1;
      end
      case (state)
        IDLE: if (app_rx_data_valid) begin
          len <= app_rx_data_length;
          port <= app_rx_port_num;
          byte0 <= app_rx_data;
          byte_cnt <= 16'd1;
          tmo_cnt <= '0;
          rx_busy <= 1'b1;
          state <= app_rx_data_length <= 16'd1 ? CHECK : RECV;
        end
        RECV: if (app_rx_data_valid) begin
          byte_cnt <= byte_cnt + 16'd1;
          tmo_cnt <= '0;
          if (byte_cnt + 16'd1 == len) state <= CHECK;
        end else if (tmo_hit) begin
          state <= IDLE;
          rx_busy <= 1'b0;
        end else tmo_cnt <= tmo_cnt + 16'd1;
        default: begin
          state <= IDLE;
          rx_busy <= 1'b0;
        end
      endcase
    end
  sat_counter8 u_ok (.clk_50(clk_50), .sys_rst_n(sys_rst_n), .inc(ok_inc), .cnt(pkt_ok_cnt));
  sat_counter8 u_err (.clk_50(clk_50), .sys_rst_n(sys_rst_n), .inc(err_inc), .cnt(pkt_err_cnt));
  sat_counter8 u_ovr (.clk_50(clk_50), .sys_rst_n(sys_rst_n), .inc(ovr_inc), .cnt(overrun_cnt));
endmodule

// File: doc/state_receiver.md
Name: state_receiver

Overview:
- Receive-side counterpart of the one-byte UDP command sender; sits on the lower-machine board after the Ethernet/UDP stack's application RX interface.
- Consumes the app_rx byte stream and filters packets by destination port, length and format.
- Presents each valid 2-bit command to the local control logic with a valid/ack handshake.
- Keeps saturating status counters for good, rejected and overrun packets.

Parameters:
- LISTEN_PORT, 16'd8080: UDP port whose packets are accepted; all others are rejected.
- TIMEOUT_CYC, 16'd1000: idle clk_50 cycles inside a packet before the packet is aborted.

Ports:
- clk_50  in  1  50 MHz system clock.
- sys_rst_n  in  1  asynchronous, active-low reset.
- app_rx_data_valid  in  1  qualifies app_rx_data, one byte per cycle while high.
- app_rx_data  in  8  received payload byte.
- app_rx_data_length  in  16  payload length of the current packet; valid with the first byte.
- app_rx_port_num  in  16  destination port of the current packet; valid with the first byte.
- cmd_out  out  2  accepted command.
- cmd_valid  out  1  level signal; high while cmd_out holds an unconsumed command.
- cmd_ack  in  1  consumer acknowledge; clears cmd_valid.
- rx_busy  out  1  high while a packet is in progress (state RECV or CHECK).
- pkt_ok_cnt  out  8  accepted packets, saturating at 255.
- pkt_err_cnt  out  8  rejected or timed-out packets, saturating at 255.
- overrun_cnt  out  8  valid packets dropped because a command was still pending, saturating at 255.

Behaviour:
- Reset: state=IDLE; cmd_out=0, cmd_valid=0, rx_busy=0; all counters 0; internal byte count, timeout count, length, port and byte0 cleared.
- Reset mid-packet: state returns to IDLE, any pending command is lost, and the remaining bytes of that packet are treated as a new packet.

State machine:
- IDLE:
  - On app_rx_data_valid, latch length, port and byte0 (app_rx_data), and set byte_cnt=1.
  - If length<=1, go to CHECK; otherwise go to RECV.
- RECV:
  - Each valid byte increments byte_cnt and clears the timeout counter. Bytes after byte0 are counted but not stored.
  - When byte_cnt+1 equals the latched length on a valid byte, go to CHECK.
  - Each cycle without valid increments the timeout counter. When it reaches TIMEOUT_CYC-1, go to IDLE and increment pkt_err_cnt; no command is issued.
- CHECK (exactly 1 cycle, then IDLE):
  - The packet is good when port==LISTEN_PORT, length==1 and byte0[7:2]==0.
  - Good packet with no command pending: cmd_out<=byte0[1:0], cmd_valid<=1, increment pkt_ok_cnt.
  - Good packet with cmd_valid=1 and cmd_ack=0: drop it, increment overrun_cnt; cmd_out is unchanged.
  - Bad packet: increment pkt_err_cnt.
  - Length 0 packets are always bad.
- Handshake:
  - cmd_valid clears on the cycle after cmd_ack is sampled high.
  - cmd_ack while cmd_valid=0 is ignored.
  - cmd_ack and CHECK acceptance in the same cycle: the ack takes effect first, the new command is accepted (cmd_valid stays 1 and cmd_out updates), and it is not an overrun.
- Latency: for a 1-byte packet with its byte in cycle N, CHECK is in N+1 and cmd_valid/cmd_out are visible in N+2.
- A valid byte arriving during CHECK is lost; the upstream stack guarantees at least 1 gap cycle between packets.
- Counters hold at 255 and never wrap.
- byte_cnt is 16 bits, so lengths up to 65535 are counted correctly.

Decomposition:
- Shared package state_link_pkg holds:
  - the state encodings (IDLE/RECV/CHECK);
  - the command code constants (2'b00..2'b11 meanings shared with the sender);
  - CMD_PAD_MASK=8'hFC;
  - the default port constant, also used by the sender's configuration.
- One natural sub-module: sat_counter8 (increment-enable, saturate at 255, async reset), instantiated three times.

Test Plan:
- Port 8080, length 1, byte 8'h02 -> cmd_out=2'b10 and cmd_valid=1 exactly 2 cycles after the byte; pkt_ok_cnt=1; pulse cmd_ack -> cmd_valid=0 on the next cycle.
- Port 8081, length 1, byte 8'h01 -> no cmd_valid; pkt_err_cnt=1. Repeat with port 8080 and byte 8'h41 -> pkt_err_cnt=2.
- Port 8080, length 4, bytes 01,00,00,00 -> rx_busy high for 4 cycles, pkt_err_cnt increments, cmd_valid stays 0.
- Length 3 but only 2 bytes sent, then 1000 idle cycles -> return to IDLE at the timeout and pkt_err_cnt=1. A subsequent good packet with byte 8'h03 -> cmd_out=2'b11.
- Good packet 8'h01 left unacked, then good packet 8'h02 -> cmd_out stays 2'b01 and overrun_cnt=1. Repeat with cmd_ack asserted in the CHECK cycle -> cmd_out=2'b10 and overrun_cnt unchanged.
- 300 bad packets -> pkt_err_cnt=255. Assert sys_rst_n=0 mid-packet -> all outputs 0 at once, and the next good packet is accepted normally.
